// File: rtl/seg7_scan_capture.sv
// Receive side of an 8-digit multiplexed seven-segment display: samples AN/Ca,
// decodes each settled digit back to hex and assembles complete 8-digit frames.
module seg7_scan_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an_in,
    input  logic [7:0]  ca_in,
    output logic        cap_valid,
    output logic [2:0]  cap_pos,
    output logic [3:0]  cap_code,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  invalid,
    output logic        frame_valid,
    output logic        stalled
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

    state_e r_state, w_state_next;

    logic [7:0]    r_an_m, r_an_s, r_ca_m, r_ca_s;
    logic [7:0]    r_an_p, r_ca_p;
    logic [7:0]    r_cnt;
    logic [TW-1:0] r_idle;
    logic [7:0]    r_mask;
    logic [31:0]   r_slot_code;
    logic [7:0]    r_slot_dp, r_slot_inv;
    logic          r_cap_valid, r_frame_valid, r_stalled;
    logic [2:0]    r_cap_pos;
    logic [3:0]    r_cap_code;
    logic [31:0]   r_digits;
    logic [7:0]    r_dp, r_inv;

    logic [7:0] w_an_lo;
    logic       w_an_valid;
    logic       w_changed;
    logic [2:0] w_pos;
    logic [3:0] w_code;
    logic       w_code_inv;
    logic [6:0] w_pat;
    logic       w_capture;
    logic       w_timeout;
    logic       w_frame_done;
    logic [7:0] w_mask_next;

    assign w_an_lo    = ~r_an_s;
    // Exactly one anode pulled low.
    assign w_an_valid = (w_an_lo != 8'd0) && ((w_an_lo & (w_an_lo - 8'd1)) == 8'd0);
    assign w_changed  = {r_an_s, r_ca_s} != {r_an_p, r_ca_p};
    assign w_pat      = ~r_ca_s[6:0];

    always_comb begin
        w_pos = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_an_lo[k]) w_pos = 3'(k);
        end
    end

    always_comb begin
        w_code     = 4'h0;
        w_code_inv = 1'b0;
        case (w_pat)
            7'h3F: w_code = 4'h0;
            7'h06: w_code = 4'h1;
            7'h5B: w_code = 4'h2;
            7'h4F: w_code = 4'h3;
            7'h66: w_code = 4'h4;
            7'h6D: w_code = 4'h5;
            7'h7D: w_code = 4'h6;
            7'h07: w_code = 4'h7;
            7'h7F: w_code = 4'h8;
            7'h6F: w_code = 4'h9;
            7'h77: w_code = 4'hA;
            7'h7C: w_code = 4'hB;
            7'h39: w_code = 4'hC;
            7'h5E: w_code = 4'hD;
            7'h79: w_code = 4'hE;
            7'h71: w_code = 4'hF;
            default: w_code_inv = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_an_valid) w_state_next = StSettle;
            end
            StSettle: begin
                if (!w_an_valid) begin
                    w_state_next = StIdle;
                end else if (!w_changed && r_cnt == 8'(SETTLE_CYCLES)) begin
                    w_capture    = 1'b1;
                    w_state_next = StHeld;
                end
            end
            StHeld: begin
                if (w_changed) w_state_next = w_an_valid ? StSettle : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // A capture in the same cycle pre-empts the timeout.
    assign w_timeout    = !w_capture && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_frame_done = (r_mask == 8'hFF);

    always_comb begin
        w_mask_next = (w_frame_done || w_timeout) ? 8'h00 : r_mask;
        if (w_capture) w_mask_next[w_pos] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_m <= 8'h00;
            r_an_s <= 8'h00;
            r_ca_m <= 8'h00;
            r_ca_s <= 8'h00;
            r_an_p <= 8'h00;
            r_ca_p <= 8'h00;
        end else begin
            r_an_m <= an_in;
            r_an_s <= r_an_m;
            r_ca_m <= ca_in;
            r_ca_s <= r_ca_m;
            r_an_p <= r_an_s;
            r_ca_p <= r_ca_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_changed) begin
                r_cnt <= 8'd1;
            end else if (r_cnt < 8'(SETTLE_CYCLES)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle    <= '0;
            r_stalled <= 1'b0;
        end else if (w_capture) begin
            r_idle    <= '0;
            r_stalled <= 1'b0;
        end else begin
            if (r_idle != TW'(TIMEOUT_CYCLES)) r_idle <= r_idle + 1'b1;
            if (w_timeout) r_stalled <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask        <= 8'h00;
            r_slot_code   <= 32'd0;
            r_slot_dp     <= 8'h00;
            r_slot_inv    <= 8'h00;
            r_cap_valid   <= 1'b0;
            r_cap_pos     <= 3'd0;
            r_cap_code    <= 4'd0;
            r_digits      <= 32'd0;
            r_dp          <= 8'h00;
            r_inv         <= 8'hFF;
            r_frame_valid <= 1'b0;
        end else begin
            r_mask        <= w_mask_next;
            r_cap_valid   <= w_capture;
            r_frame_valid <= w_frame_done;
            if (w_capture) begin
                r_slot_code[{w_pos, 2'b00} +: 4] <= w_code;
                r_slot_dp[w_pos]                 <= ~r_ca_s[7];
                r_slot_inv[w_pos]                <= w_code_inv;
                r_cap_pos                        <= w_pos;
                r_cap_code                       <= w_code;
            end
            if (w_frame_done) begin
                r_digits <= r_slot_code;
                r_dp     <= r_slot_dp;
                r_inv    <= r_slot_inv;
            end
        end
    end

    assign cap_valid   = r_cap_valid;
    assign cap_pos     = r_cap_pos;
    assign cap_code    = r_cap_code;
    assign digits      = r_digits;
    assign dp          = r_dp;
    assign invalid     = r_inv;
    assign frame_valid = r_frame_valid;
    assign stalled     = r_stalled;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans digit patterns onto AN/Ca and
// checks captures, frames, invalid/dp flags, timeout and reset behaviour.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an_in = 8'hFF;
    logic [7:0]  ca_in = 8'hFF;
    logic        cap_valid;
    logic [2:0]  cap_pos;
    logic [3:0]  cap_code;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  invalid;
    logic        frame_valid;
    logic        stalled;

    seg7_scan_capture #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .an_in      (an_in),
        .ca_in      (ca_in),
        .cap_valid  (cap_valid),
        .cap_pos    (cap_pos),
        .cap_code   (cap_code),
        .digits     (digits),
        .dp         (dp),
        .invalid    (invalid),
        .frame_valid(frame_valid),
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         cap_cnt = 0;
    int         frm_cnt = 0;
    int         err_pulse = 0;
    int         err_frame = 0;
    int         err_stall = 0;
    logic       prev_cap = 1'b0;
    logic       prev_frm = 1'b0;
    logic [2:0] pos_log [0:255];
    int         cyc_log [0:255];

    always @(negedge clk) begin
        if (rst) begin
            prev_cap <= 1'b0;
            prev_frm <= 1'b0;
        end else begin
            if (cap_valid) begin
                pos_log[cap_cnt % 256] <= cap_pos;
                cyc_log[cap_cnt % 256] <= cyc;
                cap_cnt <= cap_cnt + 1;
                if (prev_cap) err_pulse <= err_pulse + 1;
                if (stalled) err_stall <= err_stall + 1;
            end
            if (frame_valid) begin
                frm_cnt <= frm_cnt + 1;
                if (!prev_cap || prev_frm) err_frame <= err_frame + 1;
            end
            prev_cap <= cap_valid;
            prev_frm <= frame_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Active-low cathode drive for a hex digit, dp optionally lit.
    function automatic logic [7:0] seg(input logic [3:0] d, input logic dp_on);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return ~{dp_on, p};
    endfunction

    task automatic show(input int pos, input logic [7:0] ca, input int n);
        an_in = ~(8'h01 << pos);
        ca_in = ca;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        an_in = 8'hFF;
        ca_in = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0, base_c, base_f;
        logic [3:0] dg [0:7];

        // Reset values and quiet bus.
        @(negedge clk);
        do_reset();
        check("rst_digits", digits, 32'h0);
        check("rst_dp", {24'h0, dp}, 32'h0);
        check("rst_invalid", {24'h0, invalid}, 32'hFF);
        check("rst_cap_pos", {29'h0, cap_pos}, 32'h0);
        check("rst_cap_code", {28'h0, cap_code}, 32'h0);
        check("rst_pulses", {30'h0, cap_valid, frame_valid}, 32'h0);
        check("rst_stalled", {31'h0, stalled}, 32'h0);
        base_c = cap_cnt;
        base_f = frm_cnt;
        blank(100);
        check("quiet_caps", cap_cnt - base_c, 0);
        check("quiet_frames", frm_cnt - base_f, 0);

        // Full frame 5,2,2,4,3,2,1,0.
        dg[0] = 4'h5; dg[1] = 4'h2; dg[2] = 4'h2; dg[3] = 4'h4;
        dg[4] = 4'h3; dg[5] = 4'h2; dg[6] = 4'h1; dg[7] = 4'h0;
        base_c = cap_cnt;
        base_f = frm_cnt;
        c0 = cyc;
        show(0, 8'h92, 40);
        check("pos0_code", {28'h0, cap_code}, 32'h5);
        check("cap_latency", cyc_log[base_c % 256] - c0, 19);
        for (int i = 1; i < 8; i++) show(i, seg(dg[i], 1'b0), 40);
        blank(5);
        check("full_caps", cap_cnt - base_c, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("full_pos%0d", i), {29'h0, pos_log[(base_c + i) % 256]}, i);
        check("full_frames", frm_cnt - base_f, 1);
        check("full_digits", digits, 32'h01234225);
        check("full_dp", {24'h0, dp}, 32'h0);
        check("full_invalid", {24'h0, invalid}, 32'h0);

        // Short dwell on pos3; dp lit on pos5.
        base_c = cap_cnt;
        base_f = frm_cnt;
        for (int i = 0; i < 8; i++)
            show(i, seg(4'(8 + i), i == 5), (i == 3) ? 16 : 40);
        blank(5);
        check("short_caps", cap_cnt - base_c, 7);
        check("short_no_frame", frm_cnt - base_f, 0);
        show(3, seg(4'hB, 1'b0), 40);
        blank(5);
        check("short_frame", frm_cnt - base_f, 1);
        check("short_digits", digits, 32'hFEDCBA98);
        check("short_dp", {24'h0, dp}, 32'h20);

        // Blank and undecodable patterns.
        base_f = frm_cnt;
        show(0, seg(4'h1, 1'b0), 40);
        show(1, seg(4'h3, 1'b0), 40);
        show(2, 8'hFF, 40);
        check("blank_code", {28'h0, cap_code}, 32'h0);
        show(3, seg(4'h5, 1'b0), 40);
        show(4, seg(4'h6, 1'b0), 40);
        show(5, seg(4'h7, 1'b0), 40);
        show(6, 8'h7E, 40);
        check("bad_code", {28'h0, cap_code}, 32'h0);
        check("bad_pos", {29'h0, cap_pos}, 32'h6);
        show(7, seg(4'h9, 1'b0), 40);
        blank(5);
        check("inv_frame", frm_cnt - base_f, 1);
        check("inv_invalid", {24'h0, invalid}, 32'h44);
        check("inv_dp", {24'h0, dp}, 32'h40);
        check("inv_digits", digits, 32'h90765031);

        // Multiple anodes low is never a digit.
        base_c = cap_cnt;
        an_in = 8'hF0;
        ca_in = seg(4'h8, 1'b0);
        repeat (200) @(negedge clk);
        blank(5);
        check("illegal_an_caps", cap_cnt - base_c, 0);

        // Timeout drops the partial frame.
        for (int i = 0; i < 3; i++) show(i, seg(4'hF, 1'b0), 40);
        blank(900);
        check("pre_timeout", {31'h0, stalled}, 32'h0);
        blank(200);
        check("timeout_stalled", {31'h0, stalled}, 32'h1);
        base_f = frm_cnt;
        show(3, seg(4'h3, 1'b0), 40);
        check("stall_cleared", {31'h0, stalled}, 32'h0);
        for (int i = 4; i < 8; i++) show(i, seg(4'(i), 1'b0), 40);
        blank(5);
        check("mask_cleared", frm_cnt - base_f, 0);
        for (int i = 0; i < 3; i++) show(i, seg(4'(i), 1'b0), 40);
        blank(5);
        check("post_stall_frame", frm_cnt - base_f, 1);
        check("post_stall_digits", digits, 32'h76543210);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) show(i, seg(4'h9, 1'b0), 40);
        do_reset();
        check("midrst_digits", digits, 32'h0);
        check("midrst_invalid", {24'h0, invalid}, 32'hFF);
        base_f = frm_cnt;
        for (int i = 4; i < 8; i++) show(i, seg(4'h2, 1'b0), 40);
        blank(5);
        check("midrst_no_frame", frm_cnt - base_f, 0);
        for (int i = 0; i < 4; i++) show(i, seg(4'h1, 1'b0), 40);
        blank(5);
        check("midrst_frame", frm_cnt - base_f, 1);
        check("midrst_new_digits", digits, 32'h22221111);

        check("pulse_width", err_pulse, 0);
        check("frame_after_cap", err_frame, 0);
        check("stalled_at_cap", err_stall, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
